sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- Control/sequencing stage directly downstream of the A, B and instruction register bank in the SAP-style datapath.
- Consumes the instruction register output and ALU status.
- Steps a T-state counter and emits the 16-bit control word that drives the register load/output enables, PC, MAR, RAM, ALU and output port.
- Holds the carry/zero flags register and the halt state.

Parameters:
- EARLY_END, 1: 1 = return to T1 right after an instruction's last active step; 0 = always run T1..T5.
- CW_W, 16: control word width (fixed by package bit map; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  1 = advance; 0 = freeze T-state, ctrl forced to 0
- instr  in  8  instruction register output; opcode = instr[7:4]
- alu_carry  in  1  ALU carry out
- alu_zero  in  1  ALU result == 0
- ctrl  out  16  control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI
- tstate  out  3  current step, encoded 1..5 (T1..T5)
- flag_c  out  1  registered carry flag
- flag_z  out  1  registered zero flag
- halted  out  1  1 once HLT has executed

Behaviour:
- Reset (async assert, sync release): tstate=1, flag_c=0, flag_z=0, halted=0.
- ctrl is combinational from (tstate, opcode, flags, run, halted). No registered delay: the word for Tn is valid throughout the cycle in which tstate=n.
- Fetch, all opcodes:
  - T1 = CO|MI (0x4004)
  - T2 = RO|II|CE (0x1408)
- Opcode decode, valid from T3 onward; IR is stable after T2:
  - 0x0 NOP: T3 = 0
  - 0x1 LDA: T3 = IO|MI (0x4800); T4 = RO|AI (0x1200)
  - 0x2 ADD: T3 = 0x4800; T4 = RO|BI (0x1020); T5 = EO|AI|FI (0x0281)
  - 0x3 SUB: as ADD, but T5 = EO|AI|SU|FI (0x02C1)
  - 0x4 STA: T3 = 0x4800; T4 = AO|RI (0x2100)
  - 0x5 LDI: T3 = IO|AI (0x0A00)
  - 0x6 JMP: T3 = IO|J (0x0802)
  - 0x7 JC: T3 = 0x0802 if flag_c, else 0
  - 0x8 JZ: T3 = 0x0802 if flag_z, else 0
  - 0xE OUT: T3 = AO|OI (0x0110)
  - 0xF HLT: T3 = HLT (0x8000)
  - Undefined opcodes behave as NOP.
- Last step per opcode: T5 for ADD/SUB, T4 for LDA/STA, T3 for all others.
- Step advance, on a rising edge with run=1 and halted=0:
  - If EARLY_END=1 and this is the opcode's last step: tstate -> 1.
  - Else if tstate=5: tstate -> 1.
  - Else: tstate -> tstate+1.
  - With EARLY_END=0, inactive steps output ctrl=0.
- Flags:
  - flag_c <= alu_carry and flag_z <= alu_zero on an edge where ctrl[0] (FI) is 1.
  - Otherwise the flags hold.
  - JC/JZ at T3 use the flag values registered before that edge.
- Halt:
  - On an edge in T3 with opcode 0xF and run=1: halted <= 1, tstate holds at 3.
  - While halted: ctrl = 0x8000 regardless of run, and no flag updates.
  - Only rst leaves the halted state.
- run=0: ctrl = 0x0000 (HLT bit included, unless halted), and tstate and flags hold. run rising resumes at the same step.
- rst asserted mid-instruction: immediate return to T1 with flags cleared; partially executed instruction is abandoned.

Decomposition:
- Package sap_pkg:
  - opcode constants (OP_NOP..OP_HLT)
  - ctrl bit index constants and named control-word constants (CW_FETCH1, CW_FETCH2, ...)
  - T-state encoding constants T1..T5
- Sub-module sap_microcode_rom: purely combinational (tstate, opcode, flag_c, flag_z) -> raw 16-bit word plus last_step flag.
- The top holds the T-state counter, flags register, halt logic and run/halt gating.

Test Plan:
- Reset, then run=1, instr=0x1A (LDA) -> tstate 1,2,3,4,1; ctrl 0x4004, 0x1408, 0x4800, 0x1200, 0x4004.
- SUB with alu_carry=1, alu_zero=1 held during T5 -> ctrl=0x02C1 at T5; flag_c=1 and flag_z=1 after that edge. Next instr JZ (0x83) -> T3 ctrl=0x0802.
- Flags cleared, JC (0x75) -> T3 ctrl=0x0000, then tstate returns to 1.
- run dropped during T4 of ADD for 3 cycles -> ctrl=0 and tstate stays 4. After run=1 -> ctrl=0x1020, then T5=0x0281.
- HLT (0xF0) -> T3 ctrl=0x8000; halted=1 thereafter with ctrl stuck at 0x8000 for 10 cycles with run toggling. rst -> tstate=1, halted=0.
- EARLY_END=0, LDI (0x57) -> T3=0x0A00, T4=0, T5=0, then T1. Async rst pulse mid-T4 of any opcode -> tstate=1 before the next edge, flags=0.

Source files
------------

// File: rtl/sap_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sap_pkg : opcodes, control-word bit map and T-state encoding     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sap_pkg;

   localparam int CW_WIDTH = 16;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int CW_HLT_BIT = 15;
   localparam int CW_MI_BIT  = 14;
   localparam int CW_RI_BIT  = 13;
   localparam int CW_RO_BIT  = 12;
   localparam int CW_IO_BIT  = 11;
   localparam int CW_II_BIT  = 10;
   localparam int CW_AI_BIT  = 9;
   localparam int CW_AO_BIT  = 8;
   localparam int CW_EO_BIT  = 7;
   localparam int CW_SU_BIT  = 6;
   localparam int CW_BI_BIT  = 5;
   localparam int CW_OI_BIT  = 4;
   localparam int CW_CE_BIT  = 3;
   localparam int CW_CO_BIT  = 2;
   localparam int CW_J_BIT   = 1;
   localparam int CW_FI_BIT  = 0;

   function automatic logic [CW_WIDTH-1:0] cw_bit(input int idx);
      return CW_WIDTH'(1) << idx;
   endfunction

   localparam logic [CW_WIDTH-1:0] CW_NONE    = '0;
   localparam logic [CW_WIDTH-1:0] CW_FETCH1  = cw_bit(CW_CO_BIT) | cw_bit(CW_MI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_FETCH2  = cw_bit(CW_RO_BIT) | cw_bit(CW_II_BIT) | cw_bit(CW_CE_BIT);
   localparam logic [CW_WIDTH-1:0] CW_IR_ADDR = cw_bit(CW_IO_BIT) | cw_bit(CW_MI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_LOAD_A  = cw_bit(CW_RO_BIT) | cw_bit(CW_AI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_LOAD_B  = cw_bit(CW_RO_BIT) | cw_bit(CW_BI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_ADD     = cw_bit(CW_EO_BIT) | cw_bit(CW_AI_BIT) | cw_bit(CW_FI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_SUB     = CW_ADD | cw_bit(CW_SU_BIT);
   localparam logic [CW_WIDTH-1:0] CW_STORE_A = cw_bit(CW_AO_BIT) | cw_bit(CW_RI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_LDI     = cw_bit(CW_IO_BIT) | cw_bit(CW_AI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_JUMP    = cw_bit(CW_IO_BIT) | cw_bit(CW_J_BIT);
   localparam logic [CW_WIDTH-1:0] CW_OUT     = cw_bit(CW_AO_BIT) | cw_bit(CW_OI_BIT);
   localparam logic [CW_WIDTH-1:0] CW_HALT    = cw_bit(CW_HLT_BIT);

   typedef enum logic [2:0] {
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4,
      T5 = 3'd5
   } tstate_t;

endpackage
`default_nettype wire

// File: rtl/sap_microcode_rom.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sap_microcode_rom : (T-state, opcode, flags) -> raw control word |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sap_microcode_rom
   import sap_pkg::*;
(
   input  tstate_t              i_tstate,
   input  logic [3:0]           i_opcode,
   input  logic                 i_flag_c,
   input  logic                 i_flag_z,
   output logic [CW_WIDTH-1:0]  o_word,
   output logic                 o_last_step
);

   always_comb begin
      o_word      = CW_NONE;
      o_last_step = 1'b0;
      case (i_tstate)
         T1: o_word = CW_FETCH1;
         T2: o_word = CW_FETCH2;
         T3: begin
            // single-step opcodes (and undefined ones) finish here
            o_last_step = 1'b1;
            case (i_opcode)
               OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                  o_word      = CW_IR_ADDR;
                  o_last_step = 1'b0;
               end
               OP_LDI: o_word = CW_LDI;
               OP_JMP: o_word = CW_JUMP;
               OP_JC:  o_word = i_flag_c ? CW_JUMP : CW_NONE;
               OP_JZ:  o_word = i_flag_z ? CW_JUMP : CW_NONE;
               OP_OUT: o_word = CW_OUT;
               OP_HLT: o_word = CW_HALT;
               default: o_word = CW_NONE;
            endcase
         end
         T4: begin
            case (i_opcode)
               OP_LDA: begin
                  o_word      = CW_LOAD_A;
                  o_last_step = 1'b1;
               end
               OP_STA: begin
                  o_word      = CW_STORE_A;
                  o_last_step = 1'b1;
               end
               OP_ADD, OP_SUB: o_word = CW_LOAD_B;
               default: o_word = CW_NONE;
            endcase
         end
         T5: begin
            o_last_step = 1'b1;
            case (i_opcode)
               OP_ADD:  o_word = CW_ADD;
               OP_SUB:  o_word = CW_SUB;
               default: o_word = CW_NONE;
            endcase
         end
         default: o_word = CW_NONE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sap_control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sap_control_sequencer : T-state counter, flags, halt, ctrl word  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sap_control_sequencer
   import sap_pkg::*;
#(
   parameter bit EARLY_END = 1'b1,
   parameter int CW_W      = 16
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_run,
   input  logic [7:0]      i_instr,
   input  logic            i_alu_carry,
   input  logic            i_alu_zero,
   output logic [CW_W-1:0] o_ctrl,
   output logic [2:0]      o_tstate,
   output logic            o_flag_c,
   output logic            o_flag_z,
   output logic            o_halted
);

   tstate_t               r_tstate;
   tstate_t               w_tstate_nxt;
   logic                  r_flag_c;
   logic                  r_flag_z;
   logic                  r_halted;
   logic [3:0]            w_opcode;
   logic [CW_WIDTH-1:0]   w_raw;
   logic [CW_WIDTH-1:0]   w_ctrl;
   logic                  w_last;
   logic                  w_advance;
   logic                  w_halt_now;
   logic                  w_unused_operand;

   assign w_opcode         = i_instr[7:4];
   assign w_unused_operand = ^i_instr[3:0];

   sap_microcode_rom u_rom (
      .i_tstate    (r_tstate),
      .i_opcode    (w_opcode),
      .i_flag_c    (r_flag_c),
      .i_flag_z    (r_flag_z),
      .o_word      (w_raw),
      .o_last_step (w_last)
   );

   assign w_advance  = i_run & ~r_halted;
   assign w_halt_now = (r_tstate == T3) && (w_opcode == OP_HLT);
   // halted wins over run so the HLT line stays asserted while frozen
   assign w_ctrl     = r_halted ? CW_HALT : (i_run ? w_raw : CW_NONE);

   always_comb begin
      w_tstate_nxt = r_tstate;
      if (w_advance) begin
         if (w_halt_now) begin
            w_tstate_nxt = r_tstate;
         end else if (EARLY_END && w_last) begin
            w_tstate_nxt = T1;
         end else begin
            case (r_tstate)
               T1:      w_tstate_nxt = T2;
               T2:      w_tstate_nxt = T3;
               T3:      w_tstate_nxt = T4;
               T4:      w_tstate_nxt = T5;
               default: w_tstate_nxt = T1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tstate <= T1;
      end else begin
         r_tstate <= w_tstate_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flag_c <= 1'b0;
         r_flag_z <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         if (w_ctrl[CW_FI_BIT]) begin
            r_flag_c <= i_alu_carry;
            r_flag_z <= i_alu_zero;
         end
         if (w_advance && w_halt_now) begin
            r_halted <= 1'b1;
         end
      end
   end

   assign o_ctrl   = w_ctrl;
   assign o_tstate = r_tstate;
   assign o_flag_c = r_flag_c;
   assign o_flag_z = r_flag_z;
   assign o_halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_sap_control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sap_control_sequencer : directed bench, EARLY_END=1 and =0    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sap_control_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [7:0]  instr;
   logic        carry;
   logic        zero;

   logic [15:0] ctrl_e, ctrl_f;
   logic [2:0]  ts_e, ts_f;
   logic        fc_e, fz_e, h_e, fc_f, fz_f, h_f;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          sel_full;
      logic [2:0]  ts;
      logic [15:0] cw;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   sap_control_sequencer #(.EARLY_END(1'b1), .CW_W(16)) dut_early (
      .clk(clk), .rst(rst), .i_run(run), .i_instr(instr),
      .i_alu_carry(carry), .i_alu_zero(zero),
      .o_ctrl(ctrl_e), .o_tstate(ts_e), .o_flag_c(fc_e), .o_flag_z(fz_e), .o_halted(h_e)
   );

   sap_control_sequencer #(.EARLY_END(1'b0), .CW_W(16)) dut_full (
      .clk(clk), .rst(rst), .i_run(run), .i_instr(instr),
      .i_alu_carry(carry), .i_alu_zero(zero),
      .o_ctrl(ctrl_f), .o_tstate(ts_f), .o_flag_c(fc_f), .o_flag_z(fz_f), .o_halted(h_f)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs are already set at a falling edge; sample 1ns later, then cross one rising edge.
   task automatic cyc(input bit sel_full, input logic [2:0] ts, input logic [15:0] cw);
      exp_t e;
      e.sel_full = sel_full;
      e.ts       = ts;
      e.cw       = cw;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk($sformatf("%s instr=%0h T%0d tstate", e.sel_full ? "full" : "early", instr, e.ts),
          {13'd0, (e.sel_full ? ts_f : ts_e)}, {13'd0, e.ts});
      chk($sformatf("%s instr=%0h T%0d ctrl", e.sel_full ? "full" : "early", instr, e.ts),
          e.sel_full ? ctrl_f : ctrl_e, e.cw);
      @(negedge clk);
   endtask

   task automatic fetch(input bit sel_full);
      cyc(sel_full, 3'd1, 16'h4004);
      cyc(sel_full, 3'd2, 16'h1408);
   endtask

   logic [7:0]  op_tbl [6] = '{8'h57, 8'h63, 8'hE0, 8'h00, 8'hB5, 8'hC9};
   logic [15:0] cw_tbl [6] = '{16'h0A00, 16'h0802, 16'h0110, 16'h0000, 16'h0000, 16'h0000};

   initial begin
      rst = 1'b1; run = 1'b0; instr = 8'h00; carry = 1'b0; zero = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset tstate", {13'd0, ts_e}, 16'd1);
      chk("reset flag_c", {15'd0, fc_e}, 16'd0);
      chk("reset flag_z", {15'd0, fz_e}, 16'd0);
      chk("reset halted", {15'd0, h_e}, 16'd0);
      chk("reset ctrl run0", ctrl_e, 16'h0000);
      @(negedge clk);

      // LDA
      run = 1'b1; instr = 8'h1A;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h4800);
      cyc(1'b0, 3'd4, 16'h1200);
      // SUB setting both flags
      instr = 8'h3A;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h4800);
      cyc(1'b0, 3'd4, 16'h1020);
      carry = 1'b1; zero = 1'b1;
      cyc(1'b0, 3'd5, 16'h02C1);
      carry = 1'b0; zero = 1'b0;
      chk("sub flag_c", {15'd0, fc_e}, 16'd1);
      chk("sub flag_z", {15'd0, fz_e}, 16'd1);
      // JZ taken
      instr = 8'h83;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h0802);
      // ADD clearing flags
      instr = 8'h2C;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h4800);
      cyc(1'b0, 3'd4, 16'h1020);
      cyc(1'b0, 3'd5, 16'h0281);
      chk("add flag_c", {15'd0, fc_e}, 16'd0);
      chk("add flag_z", {15'd0, fz_e}, 16'd0);
      // JC and JZ not taken
      instr = 8'h75;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h0000);
      instr = 8'h81;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h0000);
      // ADD with run dropped in T4 and T5
      instr = 8'h21;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h4800);
      run = 1'b0;
      repeat (3) cyc(1'b0, 3'd4, 16'h0000);
      run = 1'b1;
      cyc(1'b0, 3'd4, 16'h1020);
      run = 1'b0; carry = 1'b1; zero = 1'b1;
      cyc(1'b0, 3'd5, 16'h0000);
      chk("frozen flag_c", {15'd0, fc_e}, 16'd0);
      chk("frozen flag_z", {15'd0, fz_e}, 16'd0);
      run = 1'b1; carry = 1'b0; zero = 1'b0;
      cyc(1'b0, 3'd5, 16'h0281);
      // STA
      instr = 8'h4D;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h4800);
      cyc(1'b0, 3'd4, 16'h2100);
      // single-step opcodes, incl. undefined
      for (int i = 0; i < 6; i++) begin
         instr = op_tbl[i];
         fetch(1'b0);
         cyc(1'b0, 3'd3, cw_tbl[i]);
      end
      // HLT
      instr = 8'hF0;
      fetch(1'b0);
      cyc(1'b0, 3'd3, 16'h8000);
      chk("halted set", {15'd0, h_e}, 16'd1);
      carry = 1'b1; zero = 1'b1;
      for (int i = 0; i < 10; i++) begin
         run = i[0];
         cyc(1'b0, 3'd3, 16'h8000);
      end
      chk("halted flag_c", {15'd0, fc_e}, 16'd0);
      chk("halted still", {15'd0, h_e}, 16'd1);
      carry = 1'b0; zero = 1'b0; run = 1'b1;
      rst = 1'b1;
      #1;
      chk("halt rst tstate", {13'd0, ts_e}, 16'd1);
      chk("halt rst halted", {15'd0, h_e}, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // EARLY_END=0 instance
      instr = 8'h57;
      fetch(1'b1);
      cyc(1'b1, 3'd3, 16'h0A00);
      cyc(1'b1, 3'd4, 16'h0000);
      cyc(1'b1, 3'd5, 16'h0000);
      instr = 8'h3F;
      fetch(1'b1);
      cyc(1'b1, 3'd3, 16'h4800);
      cyc(1'b1, 3'd4, 16'h1020);
      carry = 1'b1; zero = 1'b1;
      cyc(1'b1, 3'd5, 16'h02C1);
      carry = 1'b0; zero = 1'b0;
      chk("full sub flag_c", {15'd0, fc_f}, 16'd1);
      chk("full sub flag_z", {15'd0, fz_f}, 16'd1);
      instr = 8'h12;
      fetch(1'b1);
      cyc(1'b1, 3'd3, 16'h4800);
      chk("full lda T4 ctrl", ctrl_f, 16'h1200);
      rst = 1'b1;
      #1;
      chk("async rst tstate", {13'd0, ts_f}, 16'd1);
      chk("async rst flag_c", {15'd0, fc_f}, 16'd0);
      chk("async rst flag_z", {15'd0, fz_f}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
